// File: rtl/usb_rx_deser_pkg.sv
// Shared line-symbol constants and receiver state encoding for the USB low-speed receive path.
package types;

  typedef logic [1:0] d_port_t;

  // Bit 0 is D+, bit 1 is D-; low-speed idle (J) has D- high.
  localparam d_port_t J   = 2'b10;
  localparam d_port_t K   = 2'b01;
  localparam d_port_t SE0 = 2'b00;
  localparam d_port_t SE1 = 2'b11;

  localparam int STUFF_LEN = 6;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ERROR
  } rx_state_t;

endpackage

// File: rtl/usb_rx_deser_unstuff.sv
// NRZI decoder and bit-unstuffer: tracks the last J/K symbol and the run of decoded ones,
// flags bits to drop after a full run of ones and a run that is one bit too long.
module usb_nrzi_unstuff
  import types::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  d_port_t d,
  input  logic    strobe,
  input  logic    clear,
  output logic    bit_out,
  output logic    bit_valid,
  output logic    stuff_err,
  output logic    sym_j,
  output logic    sym_k,
  output logic    sym_se0,
  output logic    sym_se1
);

  d_port_t    prev_sym_reg;
  logic [2:0] ones_reg;
  logic       sym_jk;
  logic       at_limit;

  assign sym_j    = (d == J);
  assign sym_k    = (d == K);
  assign sym_se0  = (d == SE0);
  assign sym_se1  = (d == SE1);
  assign sym_jk   = sym_j | sym_k;
  assign bit_out  = (d == prev_sym_reg);
  assign at_limit = (ones_reg == 3'(STUFF_LEN));

  // A zero right after a full run of ones is the stuffed bit and is dropped.
  assign bit_valid = strobe & sym_jk & ~(at_limit & ~bit_out);
  assign stuff_err = strobe & sym_jk & at_limit & bit_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_sym_reg <= J;
      ones_reg     <= '0;
    end else if (clear) begin
      prev_sym_reg <= J;
      ones_reg     <= '0;
    end else if (strobe) begin
      if (sym_jk) begin
        prev_sym_reg <= d;
        if (!bit_out) begin
          ones_reg <= '0;
        end else if (ones_reg != 3'd7) begin
          ones_reg <= ones_reg + 3'd1;
        end
      end else begin
        ones_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/usb_rx_deser.sv
// USB low-speed receive deserializer: SYNC hunt, byte assembly (LSB first), EOP and error framing
// on top of the NRZI/unstuff front end.
module usb_rx_deser
  import types::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  d_port_t    d,
  input  logic       strobe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error,
  output logic       eop
);

  rx_state_t  state_reg, state_next;
  logic [2:0] zero_cnt_reg, zero_cnt_next;
  logic [2:0] se0_cnt_reg, se0_cnt_next;
  logic [3:0] j_cnt_reg, j_cnt_next;
  logic [7:0] shreg_reg, shreg_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       rx_active_reg, rx_active_next;
  logic       rx_error_reg, rx_error_next;
  logic       eop_reg, eop_next;

  logic clear;
  logic bit_out, bit_valid, stuff_err;
  logic sym_j, sym_k, sym_se0, sym_se1;

  usb_nrzi_unstuff u_unstuff (
    .clk       (clk),
    .reset_n   (reset_n),
    .d         (d),
    .strobe    (strobe),
    .clear     (clear),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .stuff_err (stuff_err),
    .sym_j     (sym_j),
    .sym_k     (sym_k),
    .sym_se0   (sym_se0),
    .sym_se1   (sym_se1)
  );

  always_comb begin
    state_next    = state_reg;
    zero_cnt_next = zero_cnt_reg;
    se0_cnt_next  = se0_cnt_reg;
    j_cnt_next    = j_cnt_reg;
    shreg_next    = shreg_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_error_next = 1'b0;
    eop_next      = 1'b0;
    clear         = 1'b0;

    if (strobe) begin
      case (state_reg)
        IDLE: begin
          if (sym_k) begin
            state_next    = SYNC;
            zero_cnt_next = 3'd1;
          end else if (sym_se1) begin
            state_next = ERROR;
          end
        end
        SYNC: begin
          if (sym_se0 || sym_se1) begin
            state_next = IDLE;
          end else if (!bit_out) begin
            if (zero_cnt_reg != 3'd7) zero_cnt_next = zero_cnt_reg + 3'd1;
          end else if (zero_cnt_reg >= 3'd3) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
        DATA: begin
          if (sym_se1) begin
            state_next = ERROR;
          end else if (sym_se0) begin
            if (bit_cnt_reg != 3'd0) begin
              state_next = ERROR;
            end else begin
              state_next   = EOP;
              se0_cnt_next = 3'd1;
            end
          end else if (stuff_err) begin
            state_next = ERROR;
          end else if (bit_valid) begin
            shreg_next   = {bit_out, shreg_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data_next  = {bit_out, shreg_reg[7:1]};
              rx_valid_next = 1'b1;
            end
          end
        end
        EOP: begin
          if (sym_se0) begin
            if (se0_cnt_reg == 3'd3) begin
              state_next = ERROR;
            end else begin
              se0_cnt_next = se0_cnt_reg + 3'd1;
            end
          end else if (sym_j) begin
            state_next = IDLE;
            eop_next   = 1'b1;
          end else begin
            state_next = ERROR;
          end
        end
        ERROR: begin
          if (sym_j) begin
            if (j_cnt_reg == 4'd7) begin
              state_next = IDLE;
            end else begin
              j_cnt_next = j_cnt_reg + 4'd1;
            end
          end else begin
            j_cnt_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Every way into ERROR reports once and restarts the J-run count.
    if (state_next == ERROR && state_reg != ERROR) begin
      rx_error_next = 1'b1;
      j_cnt_next    = '0;
    end
    if (state_next == IDLE && state_reg != IDLE) clear = 1'b1;

    rx_active_next = (state_next == DATA) || (state_next == EOP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      zero_cnt_reg  <= '0;
      se0_cnt_reg   <= '0;
      j_cnt_reg     <= '0;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      rx_active_reg <= 1'b0;
      rx_error_reg  <= 1'b0;
      eop_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      zero_cnt_reg  <= zero_cnt_next;
      se0_cnt_reg   <= se0_cnt_next;
      j_cnt_reg     <= j_cnt_next;
      shreg_reg     <= shreg_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      rx_active_reg <= rx_active_next;
      rx_error_reg  <= rx_error_next;
      eop_reg       <= eop_next;
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_active = rx_active_reg;
  assign rx_error  = rx_error_reg;
  assign eop       = eop_reg;

endmodule
